// File: rtl/noc_injection_arbiter_pkg.sv
// Shared flit-type encodings and lock-state type for the NoC injection path.
package noc_injection_arbiter_pkg;

    localparam int FLIT_TYPE_W = 2;

    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEADER   = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY     = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL     = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEADTAIL = 2'b11;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // A packet opener is illegal inside a packet, a continuation is illegal outside one.
    function automatic logic flit_order_error(input lock_state_e st,
                                              input logic [FLIT_TYPE_W-1:0] ftype);
        logic err;
        if (st == LOCK_IDLE) begin
            err = (ftype == FLIT_BODY) || (ftype == FLIT_TAIL);
        end else begin
            err = (ftype == FLIT_HEADER) || (ftype == FLIT_HEADTAIL);
        end
        return err;
    endfunction

endpackage

// File: rtl/noc_injection_arbiter_if.sv
// Requester-side and network-side signals of the injection arbiter.
interface noc_injection_arbiter_if #(
    parameter int NumRequesters            = 4,
    parameter int NocDataWidth             = 64,
    parameter int flitTypeSize             = 2,
    parameter int NocVirtualChannelIdWidth = 3,
    parameter int NocBroadcastWidth        = 1
);

    logic [NumRequesters*NocDataWidth-1:0]             req_flit_i;
    logic [NumRequesters*flitTypeSize-1:0]             req_flit_type_i;
    logic [NumRequesters*NocVirtualChannelIdWidth-1:0] req_vc_i;
    logic [NumRequesters*NocBroadcastWidth-1:0]        req_broadcast_i;
    logic [NumRequesters-1:0]                          req_valid_i;
    logic [NumRequesters-1:0]                          req_ready_o;

    logic [NocDataWidth-1:0]                           network_flit_o;
    logic [flitTypeSize-1:0]                           network_flit_type_o;
    logic [NocVirtualChannelIdWidth-1:0]               network_vc_o;
    logic [NocBroadcastWidth-1:0]                      network_broadcast_o;
    logic                                              network_valid_o;
    logic                                              network_ready_i;

    logic [NumRequesters-1:0]                          grant_o;
    logic                                              locked_o;
    logic                                              protocol_error_o;

    modport slave (
        input  req_flit_i, req_flit_type_i, req_vc_i, req_broadcast_i, req_valid_i,
        input  network_ready_i,
        output req_ready_o,
        output network_flit_o, network_flit_type_o, network_vc_o, network_broadcast_o,
        output network_valid_o,
        output grant_o, locked_o, protocol_error_o
    );

    modport master (
        output req_flit_i, req_flit_type_i, req_vc_i, req_broadcast_i, req_valid_i,
        output network_ready_i,
        input  req_ready_o,
        input  network_flit_o, network_flit_type_o, network_vc_o, network_broadcast_o,
        input  network_valid_o,
        input  grant_o, locked_o, protocol_error_o
    );

endinterface

// File: rtl/noc_injection_arbiter_rr.sv
// Combinational round-robin picker: rotate requests by ptr, take lowest set bit, rotate back.
module noc_rr_arbiter #(
    parameter int N    = 4,
    parameter int PtrW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o
);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;
    logic         found;

    always_comb begin
        req_rot = '0;
        gnt_rot = '0;
        gnt_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_rot[i] = req_i[PtrW'((i + int'(ptr_i)) % N)];
        end
        for (int i = 0; i < N; i++) begin
            if (req_rot[i] && !found) begin
                gnt_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt_o[PtrW'((i + int'(ptr_i)) % N)] = gnt_rot[i];
        end
    end

endmodule

// File: rtl/noc_injection_arbiter.sv
// Round-robin, packet-locked sharing of one NoC injection port with a single registered output stage.
//   state       | meaning
//   LOCK_IDLE   | no packet open, round-robin picks among valid requesters
//   LOCK_LOCKED | owner_q has sent a HEADER and holds the port until its TAIL
module noc_injection_arbiter
    import noc_injection_arbiter_pkg::*;
#(
    parameter int NumRequesters            = 4,
    parameter int NocDataWidth             = 64,
    parameter int flitTypeSize             = 2,
    parameter int NocVirtualChannelIdWidth = 3,
    parameter int NocBroadcastWidth        = 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_arstn,
    noc_injection_arbiter_if.slave bus
);

    localparam int N    = NumRequesters;
    localparam int DW   = NocDataWidth;
    localparam int TW   = flitTypeSize;
    localparam int VW   = NocVirtualChannelIdWidth;
    localparam int BW   = NocBroadcastWidth;
    localparam int PtrW = (N > 1) ? $clog2(N) : 1;

    lock_state_e     state_q, state_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;

    logic [DW-1:0]   flit_q, flit_d;
    logic [TW-1:0]   ftype_q, ftype_d;
    logic [VW-1:0]   vc_q, vc_d;
    logic [BW-1:0]   bcast_q, bcast_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [N-1:0]    arb_gnt;
    logic [N-1:0]    grant;
    logic [N-1:0]    ready;
    logic            load_en;
    logic            accept;
    logic            order_err;
    logic [PtrW-1:0] sel_idx;
    logic [DW-1:0]   sel_flit;
    logic [TW-1:0]   sel_type;
    logic [VW-1:0]   sel_vc;
    logic [BW-1:0]   sel_bcast;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    noc_rr_arbiter #(
        .N    (N),
        .PtrW (PtrW)
    ) u_rr_arbiter (
        .req_i (bus.req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    // Grant is suppressed during reset so no requester sees a handshake that the flops drop.
    always_comb begin
        load_en = !valid_q || bus.network_ready_i;
        grant   = '0;
        if (s_axis_arstn) begin
            if (state_q == LOCK_LOCKED) begin
                grant[owner_q] = 1'b1;
            end else begin
                grant = arb_gnt;
            end
        end
        ready  = grant & {N{load_en}};
        accept = |(bus.req_valid_i & ready);

        sel_idx   = '0;
        sel_flit  = '0;
        sel_type  = '0;
        sel_vc    = '0;
        sel_bcast = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_idx   = PtrW'(i);
                sel_flit  = bus.req_flit_i[i*DW +: DW];
                sel_type  = bus.req_flit_type_i[i*TW +: TW];
                sel_vc    = bus.req_vc_i[i*VW +: VW];
                sel_bcast = bus.req_broadcast_i[i*BW +: BW];
            end
        end
        order_err = flit_order_error(state_q, sel_type[FLIT_TYPE_W-1:0]);
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_arstn) begin
            state_q  <= LOCK_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Misordered flits are still forwarded; they never move the lock or the pointer.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            case (state_q)
                LOCK_IDLE: begin
                    if (sel_type[FLIT_TYPE_W-1:0] == FLIT_HEADER) begin
                        state_d = LOCK_LOCKED;
                        owner_d = sel_idx;
                    end else if (sel_type[FLIT_TYPE_W-1:0] == FLIT_HEADTAIL) begin
                        rr_ptr_d = ptr_inc(sel_idx);
                    end
                end
                LOCK_LOCKED: begin
                    if (sel_type[FLIT_TYPE_W-1:0] == FLIT_TAIL) begin
                        state_d  = LOCK_IDLE;
                        rr_ptr_d = ptr_inc(owner_q);
                    end
                end
                default: state_d = LOCK_IDLE;
            endcase
        end
    end

    always_comb begin
        flit_d  = flit_q;
        ftype_d = ftype_q;
        vc_d    = vc_q;
        bcast_d = bcast_q;
        valid_d = valid_q;
        err_d   = accept && order_err;
        if (load_en) begin
            valid_d = accept;
            if (accept) begin
                flit_d  = sel_flit;
                ftype_d = sel_type;
                vc_d    = sel_vc;
                bcast_d = sel_bcast;
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_arstn) begin
            flit_q  <= '0;
            ftype_q <= '0;
            vc_q    <= '0;
            bcast_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            flit_q  <= flit_d;
            ftype_q <= ftype_d;
            vc_q    <= vc_d;
            bcast_q <= bcast_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.req_ready_o         = ready;
        bus.grant_o             = grant;
        bus.locked_o            = (state_q == LOCK_LOCKED);
        bus.network_flit_o      = flit_q;
        bus.network_flit_type_o = ftype_q;
        bus.network_vc_o        = vc_q;
        bus.network_broadcast_o = bcast_q;
        bus.network_valid_o     = valid_q;
        bus.protocol_error_o    = err_q;
    end

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Scoreboard bench for the injection arbiter: per-requester flit queues feed the DUT, a behavioural
// arbitration model predicts grants and pushes expected output flits.
module tb_noc_injection_arbiter;
    import noc_injection_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int TW   = 2;
    localparam int VW   = 3;
    localparam int BW   = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] ftype;
        logic [VW-1:0] vc;
        logic [BW-1:0] bc;
    } flit_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_injection_arbiter_if #(
        .NumRequesters(NREQ), .NocDataWidth(DW), .flitTypeSize(TW),
        .NocVirtualChannelIdWidth(VW), .NocBroadcastWidth(BW)
    ) bus ();

    noc_injection_arbiter #(
        .NumRequesters(NREQ), .NocDataWidth(DW), .flitTypeSize(TW),
        .NocVirtualChannelIdWidth(VW), .NocBroadcastWidth(BW)
    ) dut (
        .s_axis_aclk  (clk),
        .s_axis_arstn (rst_n),
        .bus          (bus)
    );

    flit_t src_q[NREQ][$];
    flit_t sb[$];
    int    acc_log[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    seq   = 0;

    logic  m_locked;
    int    m_owner;
    int    m_rr;
    logic  m_out_valid;
    logic  m_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_flit(input int src, input logic [TW-1:0] ft);
        flit_t f;
        seq++;
        f.data  = {8'(src), 24'(seq), $urandom()};
        f.ftype = ft;
        f.vc    = VW'($urandom_range(0, 7));
        f.bc    = BW'($urandom_range(0, 1));
        src_q[src].push_back(f);
    endtask

    task automatic push_pkt(input int src, input int len);
        if (len <= 1) begin
            push_flit(src, FLIT_HEADTAIL);
        end else begin
            push_flit(src, FLIT_HEADER);
            for (int k = 0; k < len - 2; k++) push_flit(src, FLIT_BODY);
            push_flit(src, FLIT_TAIL);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_owner     = 0;
        m_rr        = 0;
        m_out_valid = 1'b0;
        m_err       = 1'b0;
        sb.delete();
    endtask

    task automatic step(input logic rdy);
        logic [NREQ*DW-1:0] fl;
        logic [NREQ*TW-1:0] ty;
        logic [NREQ*VW-1:0] vc;
        logic [NREQ*BW-1:0] bc;
        logic [NREQ-1:0]    vl;
        logic [NREQ-1:0]    m_gnt;
        logic               m_load;
        logic               acc;
        logic               viol;
        int                 sel;
        flit_t              f;

        @(negedge clk);
        fl = '0; ty = '0; vc = '0; bc = '0; vl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                vl[i]            = 1'b1;
                fl[i*DW +: DW]   = src_q[i][0].data;
                ty[i*TW +: TW]   = src_q[i][0].ftype;
                vc[i*VW +: VW]   = src_q[i][0].vc;
                bc[i*BW +: BW]   = src_q[i][0].bc;
            end
        end
        bus.req_flit_i      = fl;
        bus.req_flit_type_i = ty;
        bus.req_vc_i        = vc;
        bus.req_broadcast_i = bc;
        bus.req_valid_i     = vl;
        bus.network_ready_i = rdy;
        #1;

        m_load = !m_out_valid || rdy;
        m_gnt  = '0;
        sel    = -1;
        if (m_locked) begin
            m_gnt[m_owner] = 1'b1;
            sel            = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (sel < 0 && vl[(m_rr + k) % NREQ]) sel = (m_rr + k) % NREQ;
            end
            if (sel >= 0) m_gnt[sel] = 1'b1;
        end

        chk("grant", 64'(bus.grant_o), 64'(m_gnt));
        chk("req_ready", 64'(bus.req_ready_o), m_load ? 64'(m_gnt) : 64'd0);
        chk("locked", 64'(bus.locked_o), 64'(m_locked));
        chk("out_valid", 64'(bus.network_valid_o), 64'(m_out_valid));
        chk("proto_err", 64'(bus.protocol_error_o), 64'(m_err));

        if (m_out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                chk("out_flit", bus.network_flit_o, sb[0].data);
                chk("out_type", 64'(bus.network_flit_type_o), 64'(sb[0].ftype));
                chk("out_vc", 64'(bus.network_vc_o), 64'(sb[0].vc));
                chk("out_bcast", 64'(bus.network_broadcast_o), 64'(sb[0].bc));
                if (rdy) void'(sb.pop_front());
            end
        end

        acc  = 1'b0;
        viol = 1'b0;
        if (m_load && sel >= 0 && src_q[sel].size() > 0) begin
            acc = 1'b1;
            f   = src_q[sel].pop_front();
            sb.push_back(f);
            acc_log.push_back(sel);
            if (m_locked) begin
                viol = (f.ftype == FLIT_HEADER) || (f.ftype == FLIT_HEADTAIL);
                if (f.ftype == FLIT_TAIL) begin
                    m_locked = 1'b0;
                    m_rr     = (m_owner + 1) % NREQ;
                end
            end else begin
                viol = (f.ftype == FLIT_BODY) || (f.ftype == FLIT_TAIL);
                if (f.ftype == FLIT_HEADER) begin
                    m_locked = 1'b1;
                    m_owner  = sel;
                end else if (f.ftype == FLIT_HEADTAIL) begin
                    m_rr = (sel + 1) % NREQ;
                end
            end
        end
        if (m_load) m_out_valid = acc;
        m_err = acc && viol;
    endtask

    task automatic drain();
        int cyc = 0;
        bit busy = 1'b1;
        while (busy && cyc < 300) begin
            step(1'b1);
            cyc++;
            busy = m_out_valid || (sb.size() > 0);
            for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) busy = 1'b1;
        end
        if (busy) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic order_check(input string tag, input int n, input logic [31:0] exp);
        chk({tag, "_count"}, 64'(acc_log.size()), 64'(n));
        for (int i = 0; i < n && i < acc_log.size(); i++) begin
            chk(tag, 64'(acc_log[i]), 64'((exp >> (4*i)) & 32'hF));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(bus.network_valid_o), 64'd0);
        chk("rst_locked", 64'(bus.locked_o), 64'd0);
        chk("rst_grant", 64'(bus.grant_o), 64'd0);
        chk("rst_err", 64'(bus.protocol_error_o), 64'd0);
        chk("rst_flit", bus.network_flit_o, 64'd0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        bus.req_valid_i = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.req_flit_i      = '0;
        bus.req_flit_type_i = '0;
        bus.req_vc_i        = '0;
        bus.req_broadcast_i = '0;
        bus.req_valid_i     = '0;
        bus.network_ready_i = 1'b1;
        model_reset();
        do_reset();

        // two HEADTAIL sources alternate
        for (int k = 0; k < 4; k++) begin
            push_pkt(0, 1);
            push_pkt(2, 1);
        end
        acc_log.delete();
        drain();
        order_check("t1_order", 8, 32'h20202020);

        // wormhole lock holds req3 off until req1 finishes
        acc_log.delete();
        push_pkt(1, 4);
        step(1'b1);
        push_pkt(3, 1);
        drain();
        order_check("t2_order", 5, 32'h00031111);

        // backpressure mid-packet
        push_pkt(2, 5);
        step(1'b1);
        step(1'b1);
        repeat (5) step(1'b0);
        drain();

        // order violations, idle and locked
        push_flit(0, FLIT_BODY);
        drain();
        push_flit(0, FLIT_TAIL);
        drain();
        push_flit(1, FLIT_HEADER);
        push_flit(1, FLIT_HEADTAIL);
        push_flit(1, FLIT_TAIL);
        drain();

        // reset while locked with a held flit
        push_pkt(2, 4);
        step(1'b1);
        step(1'b0);
        chk("t5_locked_before", 64'(bus.locked_o), 64'd1);
        do_reset();

        // all four requesters, pointer restarts at 0
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) push_pkt(i, 1);
        end
        acc_log.delete();
        drain();
        order_check("t6_order", 8, 32'h32103210);

        // random traffic with random backpressure and stray flits
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 9))
                        0:       push_flit(i, FLIT_BODY);
                        1:       push_flit(i, FLIT_TAIL);
                        2: begin
                            push_flit(i, FLIT_HEADER);
                            push_flit(i, FLIT_HEADTAIL);
                            push_flit(i, FLIT_TAIL);
                        end
                        default: push_pkt(i, $urandom_range(1, 4));
                    endcase
                end
            end
            step($urandom_range(0, 3) != 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
